m00_axi_lite_master: RTL

//  AXI4-Lite master. Turns single-beat register read/write commands from local logic into AXI4-Lite transactions.
//  It is the initiator end facing the team's AXI4-Lite register-file slaves.

---
 rtl/axi_lite_pkg.sv | 27 ++
 rtl/m00_axi_lite_master_if.sv | 53 +++++
 rtl/m00_axi_lite_master.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types: default widths, payload typedefs,
// response codes and the master FSM state encoding.
package axi_lite_pkg;

    localparam int AXI_DW = 32;
    localparam int AXI_AW = 10;

    typedef logic [AXI_DW-1:0]   axi_data_t;
    typedef logic [AXI_AW-1:0]   axi_addr_t;
    typedef logic [AXI_DW/8-1:0] axi_strb_t;
    typedef logic [1:0]          axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_EXOKAY = 2'b01;
    localparam axi_resp_t RESP_SLVERR = 2'b10;
    localparam axi_resp_t RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

endpackage

// File: rtl/m00_axi_lite_master_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels).
// master modport drives AW/W/AR payload+VALID and B/R READY.
interface m00_axi_lite_master_if
    import axi_lite_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 10
);
    logic [AXI_ADDR_WIDTH-1:0]   AXI_AWADDR;
    logic                        AXI_AWVALID;
    logic                        AXI_AWREADY;
    logic [AXI_DATA_WIDTH-1:0]   AXI_WDATA;
    logic [AXI_DATA_WIDTH/8-1:0] AXI_WSTRB;
    logic                        AXI_WVALID;
    logic                        AXI_WREADY;
    axi_resp_t                   AXI_BRESP;
    logic                        AXI_BVALID;
    logic                        AXI_BREADY;
    logic [AXI_ADDR_WIDTH-1:0]   AXI_ARADDR;
    logic                        AXI_ARVALID;
    logic                        AXI_ARREADY;
    logic [AXI_DATA_WIDTH-1:0]   AXI_RDATA;
    axi_resp_t                   AXI_RRESP;
    logic                        AXI_RVALID;
    logic                        AXI_RREADY;

    modport master (
        output AXI_AWADDR, AXI_AWVALID,
        input  AXI_AWREADY,
        output AXI_WDATA, AXI_WSTRB, AXI_WVALID,
        input  AXI_WREADY,
        input  AXI_BRESP, AXI_BVALID,
        output AXI_BREADY,
        output AXI_ARADDR, AXI_ARVALID,
        input  AXI_ARREADY,
        input  AXI_RDATA, AXI_RRESP, AXI_RVALID,
        output AXI_RREADY
    );

    modport slave (
        input  AXI_AWADDR, AXI_AWVALID,
        output AXI_AWREADY,
        input  AXI_WDATA, AXI_WSTRB, AXI_WVALID,
        output AXI_WREADY,
        output AXI_BRESP, AXI_BVALID,
        input  AXI_BREADY,
        input  AXI_ARADDR, AXI_ARVALID,
        output AXI_ARREADY,
        output AXI_RDATA, AXI_RRESP, AXI_RVALID,
        input  AXI_RREADY
    );

endinterface

// File: rtl/m00_axi_lite_master.sv
// AXI4-Lite master: one single-beat read/write in flight at a time.
// Ports: AXI_ACLK/AXI_ARESET (sync, active-high), cmd_* request in,
// rsp_* result out (valid/ready), m_axi AXI4-Lite master bus.
module m00_axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 10
) (
    input  logic                        AXI_ACLK,
    input  logic                        AXI_ARESET,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_write,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output axi_resp_t                   rsp_resp,
    m00_axi_lite_master_if.master       m_axi
);

    localparam int SW = AXI_DATA_WIDTH / 8;

    state_t state_q, state_d;

    logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [SW-1:0]             wstrb_q, wstrb_d;
    axi_resp_t                 resp_q, resp_d;

    logic awvalid_q, awvalid_d;
    logic wvalid_q, wvalid_d;
    logic bready_q, bready_d;
    logic arvalid_q, arvalid_d;
    logic rready_q, rready_d;
    logic aw_done_q, aw_done_d;
    logic w_done_q, w_done_d;
    logic cready_q, cready_d;
    logic rvalid_q, rvalid_d;
    logic rwrite_q, rwrite_d;

    always_comb begin
        state_d   = state_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rvalid_d  = rvalid_q;
        rwrite_d  = rwrite_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cready_q) begin
                    if (cmd_write) begin
                        state_d   = WR_REQ;
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = RD_REQ;
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                // AW and W retire independently; leave once both have.
                if (awvalid_q && m_axi.AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && m_axi.AXI_WREADY) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (bready_q && m_axi.AXI_BVALID) begin
                    resp_d   = m_axi.AXI_BRESP;
                    rdata_d  = '0;
                    rwrite_d = 1'b1;
                    bready_d = 1'b0;
                    rvalid_d = 1'b1;
                    state_d  = RSP;
                end
            end
            RD_REQ: begin
                if (arvalid_q && m_axi.AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rready_q && m_axi.AXI_RVALID) begin
                    rdata_d  = m_axi.AXI_RDATA;
                    resp_d   = m_axi.AXI_RRESP;
                    rwrite_d = 1'b0;
                    rready_d = 1'b0;
                    rvalid_d = 1'b1;
                    state_d  = RSP;
                end
            end
            RSP: begin
                if (rvalid_q && rsp_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered so it is low for one cycle after reset release.
        cready_d = (state_d == IDLE);
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            state_q   <= IDLE;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cready_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rwrite_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            cready_q  <= cready_d;
            rvalid_q  <= rvalid_d;
            rwrite_q  <= rwrite_d;
        end
    end

    assign cmd_ready = cready_q;
    assign rsp_valid = rvalid_q;
    assign rsp_write = rwrite_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

    assign m_axi.AXI_AWADDR  = awaddr_q;
    assign m_axi.AXI_AWVALID = awvalid_q;
    assign m_axi.AXI_WDATA   = wdata_q;
    assign m_axi.AXI_WSTRB   = wstrb_q;
    assign m_axi.AXI_WVALID  = wvalid_q;
    assign m_axi.AXI_BREADY  = bready_q;
    assign m_axi.AXI_ARADDR  = araddr_q;
    assign m_axi.AXI_ARVALID = arvalid_q;
    assign m_axi.AXI_RREADY  = rready_q;

endmodule
